regfile_multiport: RTL and testbench

//  Parametrised multi-port register file for the next RISC-V core generation:
//  NRD read ports, NWR write ports, optional write-to-read bypass and optional

---
 rtl/regfile_multiport.sv | 128 ++++++++++++
 tb/tb_regfile_multiport.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// Multi-port register file with optional write-to-read bypass, optional
// registered read, and a per-register busy scoreboard for issue stalls.
module regfile_multiport #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREGS     = 32,
  parameter int unsigned NRD       = 2,
  parameter int unsigned NWR       = 2,
  parameter int unsigned SYNC_READ = 0,
  parameter int unsigned BYPASS    = 1,
  parameter int unsigned ZERO_REG  = 1,
  localparam int unsigned AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_ready,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                busy_set,
  input  logic [AW-1:0]       busy_addr,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]     r_regs [NREGS];
  logic [NREGS-1:0]    r_busy;
  logic [NWR-1:0]      w_wr_ok;
  logic [NRD-1:0]      w_hit;
  logic [NRD*XLEN-1:0] w_fwd;
  logic [NRD*XLEN-1:0] w_sel;
  logic [NREGS-1:0]    w_busy_nxt;

  always_comb begin
    for (int unsigned j = 0; j < NWR; j++) begin
      w_wr_ok[j] = wr_en[j] &&
                   !((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == '0));
    end
  end

  // Ascending scan so the highest-index matching write port ends up selected.
  always_comb begin
    w_hit = '0;
    w_fwd = '0;
    w_sel = '0;
    rd_ready = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      for (int unsigned j = 0; j < NWR; j++) begin
        if (w_wr_ok[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
          w_hit[i] = 1'b1;
          w_fwd[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
        end
      end
      if ((ZERO_REG != 0) && (rd_addr[i*AW +: AW] == '0)) begin
        w_sel[i*XLEN +: XLEN] = '0;
        rd_ready[i] = 1'b1;
      end else begin
        if ((BYPASS != 0) && w_hit[i]) begin
          w_sel[i*XLEN +: XLEN] = w_fwd[i*XLEN +: XLEN];
        end else begin
          w_sel[i*XLEN +: XLEN] = r_regs[rd_addr[i*AW +: AW]];
        end
        rd_ready[i] = !r_busy[rd_addr[i*AW +: AW]] || ((BYPASS != 0) && w_hit[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        r_regs[r] <= '0;
      end
    end else begin
      for (int unsigned j = 0; j < NWR; j++) begin
        if (w_wr_ok[j]) begin
          r_regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Clears applied before the set so a newly issued producer keeps the bit.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int unsigned j = 0; j < NWR; j++) begin
      if (wr_en[j]) begin
        w_busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (busy_set && !((ZERO_REG != 0) && (busy_addr == '0))) begin
      w_busy_nxt[busy_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy_vec = r_busy;

  generate
    if (SYNC_READ != 0) begin : g_sync
      logic [NRD*XLEN-1:0] r_rd_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_rd_q <= '0;
        end else begin
          for (int unsigned i = 0; i < NRD; i++) begin
            if (rd_en[i]) begin
              r_rd_q[i*XLEN +: XLEN] <= w_sel[i*XLEN +: XLEN];
            end
          end
        end
      end
      assign rd_data = r_rd_q;
    end else begin : g_comb
      logic w_unused_rd_en;
      assign w_unused_rd_en = ^rd_en;
      assign rd_data = w_sel;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: three configurations share one stimulus stream
// and are checked every cycle against an array-based reference model.
module tb_regfile_multiport;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  logic                clk;
  logic                reset_n;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                busy_set;
  logic [AW-1:0]       busy_addr;

  logic [NRD*XLEN-1:0] c_rd_data, n_rd_data, s_rd_data;
  logic [NRD-1:0]      c_rd_ready, n_rd_ready, s_rd_ready;
  logic [31:0]         c_busy, n_busy, s_busy;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b1;

  regfile_multiport #(.SYNC_READ(0), .BYPASS(1)) u_comb (
    .clk(clk), .reset_n(reset_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(c_rd_data), .rd_ready(c_rd_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy_set(busy_set),
    .busy_addr(busy_addr), .busy_vec(c_busy));

  regfile_multiport #(.SYNC_READ(0), .BYPASS(0)) u_nobyp (
    .clk(clk), .reset_n(reset_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(n_rd_data), .rd_ready(n_rd_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy_set(busy_set),
    .busy_addr(busy_addr), .busy_vec(n_busy));

  regfile_multiport #(.SYNC_READ(1), .BYPASS(1)) u_sync (
    .clk(clk), .reset_n(reset_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(s_rd_data), .rd_ready(s_rd_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy_set(busy_set),
    .busy_addr(busy_addr), .busy_vec(s_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_mem [32] = '{default: '0};
  logic [31:0] m_busy = '0;
  logic [31:0] m_sq [NRD] = '{default: '0};
  logic        m_h;
  logic [31:0] m_v;

  // Winning write for address a: highest-index enabled port, r0 never written.
  function automatic void wmatch(input logic [4:0] a, output logic hit, output logic [31:0] v);
    hit = 1'b0;
    v = '0;
    if (a != 0) begin
      for (int j = NWR - 1; j >= 0; j--) begin
        if (!hit && wr_en[j] && wr_addr[j*AW +: AW] == a) begin
          hit = 1'b1;
          v = wr_data[j*XLEN +: XLEN];
        end
      end
    end
  endfunction

  function automatic logic [31:0] exp_sel(input logic [4:0] a, input bit byp);
    logic h;
    logic [31:0] v;
    wmatch(a, h, v);
    if (a == 0) return 32'h0;
    if (byp && h) return v;
    return m_mem[a];
  endfunction

  function automatic logic exp_ready(input logic [4:0] a, input bit byp);
    logic h;
    logic [31:0] v;
    wmatch(a, h, v);
    if (a == 0) return 1'b1;
    return !m_busy[a] || (byp && h);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int a = 0; a < 32; a++) m_mem[a] = '0;
      m_busy = '0;
      for (int i = 0; i < NRD; i++) m_sq[i] = '0;
    end else begin
      for (int i = 0; i < NRD; i++)
        if (rd_en[i]) m_sq[i] = exp_sel(rd_addr[i*AW +: AW], 1'b1);
      for (int a = 1; a < 32; a++) begin
        wmatch(5'(a), m_h, m_v);
        if (m_h) m_mem[a] = m_v;
      end
      for (int j = 0; j < NWR; j++)
        if (wr_en[j]) m_busy[wr_addr[j*AW +: AW]] = 1'b0;
      if (busy_set && busy_addr != 0) m_busy[busy_addr] = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NRD; i++) begin
        logic [4:0] a;
        a = rd_addr[i*AW +: AW];
        check($sformatf("comb_data%0d", i), c_rd_data[i*XLEN +: XLEN], exp_sel(a, 1'b1));
        check($sformatf("nobyp_data%0d", i), n_rd_data[i*XLEN +: XLEN], exp_sel(a, 1'b0));
        check($sformatf("sync_data%0d", i), s_rd_data[i*XLEN +: XLEN], m_sq[i]);
        check($sformatf("comb_ready%0d", i), 32'(c_rd_ready[i]), 32'(exp_ready(a, 1'b1)));
        check($sformatf("nobyp_ready%0d", i), 32'(n_rd_ready[i]), 32'(exp_ready(a, 1'b0)));
        check($sformatf("sync_ready%0d", i), 32'(s_rd_ready[i]), 32'(exp_ready(a, 1'b1)));
      end
      check("comb_busy", c_busy, m_busy);
      check("nobyp_busy", n_busy, m_busy);
      check("sync_busy", s_busy, m_busy);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0;
    busy_set = 1'b0;
    rd_en = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    busy_set = 1'b0; busy_addr = '0;

    // T1: writes and busy_set under reset are ignored
    wr_en = 2'b11;
    wr_addr = {5'd6, 5'd5};
    wr_data = {32'h6666_6666, 32'h5555_5555};
    busy_set = 1'b1; busy_addr = 5'd9;
    rd_addr = {5'd8, 5'd7};
    repeat (2) @(negedge clk);
    check("t1_rd0", c_rd_data[31:0], 32'h0);
    check("t1_busy", c_busy, 32'h0);
    check("t1_ready", 32'(c_rd_ready), 32'h3);
    step();
    idle();
    reset_n = 1'b1;
    rd_addr = {5'd6, 5'd5};
    @(negedge clk);
    check("t1_r5_after", c_rd_data[31:0], 32'h0);
    check("t1_r6_after", c_rd_data[63:32], 32'h0);

    // T2: basic write/read, r0 hardwired
    step();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
    rd_addr = {5'd6, 5'd5};
    @(negedge clk);
    check("t2_byp_same", c_rd_data[31:0], 32'hDEADBEEF);
    check("t2_nobyp_same", n_rd_data[31:0], 32'h0);
    step();
    idle();
    @(negedge clk);
    check("t2_r5", c_rd_data[31:0], 32'hDEADBEEF);
    check("t2_r5_nobyp", n_rd_data[31:0], 32'hDEADBEEF);
    step();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'h1234};
    rd_addr = {5'd6, 5'd0};
    @(negedge clk);
    check("t2_r0_same", c_rd_data[31:0], 32'h0);
    step();
    idle();
    @(negedge clk);
    check("t2_r0", c_rd_data[31:0], 32'h0);
    check("t2_r0_nobyp", n_rd_data[31:0], 32'h0);

    // T3: write collision, highest port wins
    step();
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
    rd_addr = {5'd7, 5'd5};
    @(negedge clk);
    check("t3_byp_same", c_rd_data[63:32], 32'h22);
    check("t3_nobyp_same", n_rd_data[63:32], 32'h0);
    step();
    idle();
    @(negedge clk);
    check("t3_r7", c_rd_data[63:32], 32'h22);
    check("t3_r7_nobyp", n_rd_data[63:32], 32'h22);

    // T4: registered read latency and hold
    step();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'hA5};
    step();
    idle();
    rd_en = 2'b01; rd_addr = {5'd7, 5'd3};
    @(negedge clk);
    check("t4_sync_before", s_rd_data[31:0], 32'h0);
    step();
    rd_en = 2'b00; rd_addr = {5'd7, 5'd4};
    @(negedge clk);
    check("t4_sync_lat1", s_rd_data[31:0], 32'hA5);
    step();
    @(negedge clk);
    check("t4_sync_hold", s_rd_data[31:0], 32'hA5);
    step();
    wr_en = 2'b10; wr_addr = {5'd10, 5'd0}; wr_data = {32'h5A, 32'h0};
    rd_en = 2'b01; rd_addr = {5'd7, 5'd10};
    step();
    idle();
    @(negedge clk);
    check("t4_sync_byp", s_rd_data[31:0], 32'h5A);

    // T5: scoreboard
    step();
    busy_set = 1'b1; busy_addr = 5'd9; rd_addr = {5'd7, 5'd9};
    @(negedge clk);
    check("t5_ready_pre", 32'(c_rd_ready[0]), 32'h1);
    step();
    idle();
    @(negedge clk);
    check("t5_busy9", 32'(c_busy[9]), 32'h1);
    check("t5_notready", 32'(c_rd_ready[0]), 32'h0);
    step();
    wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h77, 32'h0};
    @(negedge clk);
    check("t5_byp_ready", 32'(c_rd_ready[0]), 32'h1);
    check("t5_nobyp_ready", 32'(n_rd_ready[0]), 32'h0);
    check("t5_byp_data", c_rd_data[31:0], 32'h77);
    step();
    idle();
    @(negedge clk);
    check("t5_cleared", c_busy, 32'h0);
    step();
    busy_set = 1'b1; busy_addr = 5'd9;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h88};
    step();
    idle();
    @(negedge clk);
    check("t5_set_wins", c_busy, 32'h0000_0200);
    check("t5_set_notready", 32'(c_rd_ready[0]), 32'h0);
    step();
    busy_set = 1'b1; busy_addr = 5'd0;
    step();
    idle();
    @(negedge clk);
    check("t5_r0_never_busy", c_busy, 32'h0000_0200);

    // T6: asynchronous reset between edges
    step();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd12}; wr_data = {32'h0, 32'hCAFE};
    busy_set = 1'b1; busy_addr = 5'd13;
    rd_addr = {5'd5, 5'd12};
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_busy_async", c_busy, 32'h0);
    check("t6_r5_async", c_rd_data[63:32], 32'h0);
    check("t6_r12_nobyp", n_rd_data[31:0], 32'h0);
    check("t6_sync_async", s_rd_data[31:0], 32'h0);
    step();
    idle();
    reset_n = 1'b1;
    @(negedge clk);
    check("t6_r12_dropped", n_rd_data[31:0], 32'h0);
    check("t6_busy_after", n_busy, 32'h0);

    // Mixed traffic on a narrow address range to provoke collisions
    for (int k = 0; k < 300; k++) begin
      step();
      wr_en = 2'($urandom);
      wr_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_data = {$urandom, $urandom};
      busy_set = 1'($urandom);
      busy_addr = 5'($urandom_range(0, 7));
      rd_en = 2'($urandom);
      rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    end
    step();
    idle();
    @(negedge clk);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
